tmnt_note_arbiter: RTL and testbench
====================================

// Module: tmnt_note_arbiter
// PURPOSE
//  Front-end controller for the single tone generator of the TMNT synth.
//  - Synchronises and debounces the note keys and the mode button.
//  - Arbitrates the held keys down to one active note (last-pressed wins) and cycles the output mode.
//  - Emits a one-cycle strobe on every note change so the generator reloads its divider.
//  - Sits between the breakout pushbuttons and the oscillator/sigout datapath, inside top_asic.
// PARAMETERS
//  N_KEYS   13     number of note keys (max 16)
//  DEB_DIV  50000  debounce sample period in clk cycles (5 ms @ 10 MHz)
//  ARP_DIV  1000000 arpeggio step period in clk cycles (100 ms @ 10 MHz)
// PORTS
//  clk          in   1       system clock
//  gated_reset  in   1       reset, asynchronous, active-low
//  keys         in   N_KEYS  raw note keys, active-high, asynchronous
//  mode_btn     in   1       raw mode button, active-high, asynchronous
//  note_valid   out  1       a note is active
//  note_idx     out  4       index of the active note (0..N_KEYS-1)
//  note_strobe  out  1       1-cycle pulse when note_idx changes or note_valid rises
//  mode         out  2       output mode to the generator
// BEHAVIOUR
//  Reset: all outputs 0; sync flops, debounced state, counters and FSM cleared to IDLE.
//   Reset is honoured mid-operation on any cycle.
//  Input stage: 2-FF synchroniser per input.
//   A free-running tick counter 0..DEB_DIV-1 pulses deb_tick at terminal count.
//   On deb_tick a debounced bit takes the new sample only if it equals the previous sample.
//  Edge detect: rise[i] = deb[i] & ~deb_q[i], registered one cycle after the debounce update.
//  Mode: each mode_btn rise advances mode 00->01->10->11->00 (wraps).
//  FSM IDLE / PLAY:
//   IDLE->PLAY on any key rise.
//   PLAY->IDLE when no debounced key is held; note_valid drops the same cycle.
//  Arbitration in PLAY:
//   - A key rise selects that key.
//   - Simultaneous rises: the lowest index wins.
//   - Release of the active key falls back to the lowest-index still-held key.
//   - Release of a non-active key: no change.
//   - Rise and active-key release in the same cycle: the rise wins.
//  Timing: note_idx/note_valid update 1 cycle after rise[]; note_strobe asserts in that same cycle.
//   Worst-case raw press to note_valid is 2 + 2*DEB_DIV + 2 cycles.
//  note_idx holds its last value while note_valid = 0.
// CONFIGURATION
//  TMNT_ARP_EN defined:
//   - Adds FSM state ARP and an ARP_DIV step counter.
//   - In PLAY with mode==2'b11 and >=2 keys held, the FSM enters ARP.
//   - Each step moves note_idx to the next-higher held key, wrapping to the lowest; each step pulses note_strobe.
//   - Fewer than 2 held keys returns to PLAY; no keys held goes to IDLE.
//   - A mode change away from 11 returns to PLAY with the current note kept.
//  TMNT_ARP_EN undefined: no ARP state or counter; mode 11 arbitrates exactly like other modes.
// STRUCTURE
//  Package tmnt_pkg holds:
//   - typedef enum logic [1:0] {IDLE, PLAY, ARP} arb_state_t
//   - typedef logic [3:0] note_idx_t
//   - MODE_* localparams
//   - function lowest_set(vec) -> note_idx_t
//  Sub-module tmnt_debounce: one instance per input; sync + sample-compare, shared deb_tick input.
//  The tick counter, edge detect, FSM and arbitration live in tmnt_note_arbiter.
// TESTING  (DEB_DIV=4, ARP_DIV=8 for simulation)
//  1. Hold keys[5] for 20 cycles -> note_valid=1, note_idx=5, a single note_strobe; release -> note_valid=0 within 12 cycles.
//  2. Hold keys[7], then press keys[2] -> note_idx=2 with a strobe; release keys[2] -> note_idx=7 with a strobe.
//  3. Raise keys[9] and keys[4] in the same cycle -> note_idx=4; a 1-cycle glitch on keys[0] -> no change, no strobe.
//  4. Press mode_btn 5 times -> mode sequence 01,10,11,00,01.
//  5. Assert gated_reset low mid-PLAY -> all outputs 0 immediately; after release, keys still held -> re-acquired as fresh presses.
//  6. TMNT_ARP_EN, mode=11, keys 1,3,6 held -> note_idx 1,3,6,1 every 8 cycles, each step with a strobe.

Source files
------------

// File: rtl/tmnt_pkg.sv
// Shared types and helpers for the TMNT note front end (arbiter FSM states, note index, output modes).
// Latency: n/a (types and pure combinational helper functions only).
// Backpressure: n/a.
package tmnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        ARP  = 2'd2
    } arb_state_t;

    typedef logic [3:0] note_idx_t;

    // Output modes handed to the tone generator; MODE_ARP is the one that arms the arpeggiator.
    localparam logic [1:0] MODE_0   = 2'b00;
    localparam logic [1:0] MODE_1   = 2'b01;
    localparam logic [1:0] MODE_2   = 2'b10;
    localparam logic [1:0] MODE_3   = 2'b11;
    localparam logic [1:0] MODE_ARP = MODE_3;

    localparam int MAX_KEYS = 16;

    // Index of the lowest set bit; 0 when the vector is empty (callers guard on that).
    function automatic note_idx_t lowest_set(input logic [MAX_KEYS-1:0] vec);
        note_idx_t idx;
        idx = '0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = note_idx_t'(i);
            end
        end
        return idx;
    endfunction

    // Next set bit strictly above cur, wrapping round to the lowest set bit.
    function automatic note_idx_t next_set(input logic [MAX_KEYS-1:0] vec, input note_idx_t cur);
        note_idx_t idx;
        logic      found;
        idx   = lowest_set(vec);
        found = 1'b0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (!found && (i > int'(cur)) && vec[i]) begin
                idx   = note_idx_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // True when two or more bits are set (clearing the lowest set bit leaves something behind).
    function automatic logic at_least_two(input logic [MAX_KEYS-1:0] vec);
        return (vec & (vec - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/tmnt_debounce.sv
// One-bit input conditioner: 2-FF synchroniser followed by a sample-and-compare debouncer.
// Latency: 2 clk to synchronise, then 1..2 deb_tick periods before the debounced level follows.
// Backpressure: none; free-running, output is a level.
module tmnt_debounce (
    input  logic clk,
    input  logic gated_reset,
    input  logic i_raw,
    input  logic i_deb_tick,
    output logic o_deb
);

    logic r_sync1;
    logic r_sync2;
    logic r_samp;
    logic r_deb;

    // Synchronise the raw pin, then on each tick accept the sample only if it matches the previous tick's sample.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_samp  <= 1'b0;
            r_deb   <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_deb_tick) begin
                r_samp <= r_sync2;
                if (r_sync2 == r_samp) begin
                    r_deb <= r_sync2;
                end
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/tmnt_note_arbiter.sv
// Note-key front end: debounces keys and mode button, picks one active note (last pressed wins), cycles mode.
// Latency: raw edge to note_valid/note_idx worst case 2 + 2*DEB_DIV + 2 clk; note_strobe fires with the update.
// Backpressure: none; the generator must take note_strobe the cycle it fires. TMNT_ARP_EN adds the arpeggiator.
module tmnt_note_arbiter #(
    parameter int N_KEYS  = 13,
    parameter int DEB_DIV = 50000,
    parameter int ARP_DIV = 1000000
) (
    input  logic              clk,
    input  logic              gated_reset,
    input  logic [N_KEYS-1:0] keys,
    input  logic              mode_btn,
    output logic              note_valid,
    output logic [3:0]        note_idx,
    output logic              note_strobe,
    output logic [1:0]        mode
);

    import tmnt_pkg::*;

    localparam int DEB_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    // ---------------- debounce tick and input conditioning ----------------
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_deb_tick;

    assign w_deb_tick = (r_deb_cnt == DEB_W'(DEB_DIV - 1));

    // Free-running sample timer shared by every debouncer so simultaneous presses stay simultaneous.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_deb_cnt <= '0;
        end else if (w_deb_tick) begin
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    // Mode button rides along as the top bit so it shares the key pipeline.
    logic [N_KEYS:0] w_raw;
    logic [N_KEYS:0] w_deb;

    assign w_raw = {mode_btn, keys};

    for (genvar g = 0; g <= N_KEYS; g++) begin : g_deb
        tmnt_debounce u_deb (
            .clk         (clk),
            .gated_reset (gated_reset),
            .i_raw       (w_raw[g]),
            .i_deb_tick  (w_deb_tick),
            .o_deb       (w_deb[g])
        );
    end

    // ---------------- edge detect ----------------
    logic [N_KEYS:0] r_deb_q;
    logic [N_KEYS:0] r_rise;

    // r_deb_q doubles as the held-key view, so it lines up cycle-for-cycle with r_rise.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_deb_q <= '0;
            r_rise  <= '0;
        end else begin
            r_deb_q <= w_deb;
            r_rise  <= w_deb & ~r_deb_q;
        end
    end

    logic [N_KEYS-1:0]   w_held;
    logic [N_KEYS-1:0]   w_key_rise;
    logic                w_mode_rise;
    logic [MAX_KEYS-1:0] w_held16;
    logic [MAX_KEYS-1:0] w_rise16;

    assign w_held      = r_deb_q[N_KEYS-1:0];
    assign w_key_rise  = r_rise[N_KEYS-1:0];
    assign w_mode_rise = r_rise[N_KEYS];
    assign w_held16    = MAX_KEYS'(w_held);
    assign w_rise16    = MAX_KEYS'(w_key_rise);

    // ---------------- mode ----------------
    logic [1:0] r_mode;

    // Each debounced press of the mode button steps the mode, wrapping after 11.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_mode <= MODE_0;
        end else if (w_mode_rise) begin
            r_mode <= r_mode + 2'd1;
        end
    end

    // ---------------- arbitration FSM ----------------
    arb_state_t r_state;
    arb_state_t w_state_nxt;
    note_idx_t  r_idx;
    note_idx_t  w_idx_nxt;
    logic       r_strobe;
    logic       w_strobe_nxt;

`ifdef TMNT_ARP_EN
    localparam int ARP_W = (ARP_DIV > 1) ? $clog2(ARP_DIV) : 1;

    logic [ARP_W-1:0] r_arp_cnt;
    logic             w_arp_tick;
    logic             w_arp_ok;

    assign w_arp_tick = (r_state == ARP) && (r_arp_cnt == ARP_W'(ARP_DIV - 1));
    assign w_arp_ok   = at_least_two(w_held16) && (r_mode == MODE_ARP);

    // Step timer only runs while arpeggiating, so the first step comes a full period after entry.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_arp_cnt <= '0;
        end else if ((r_state != ARP) || w_arp_tick) begin
            r_arp_cnt <= '0;
        end else begin
            r_arp_cnt <= r_arp_cnt + ARP_W'(1);
        end
    end
`else
    logic w_unused_arp;
    assign w_unused_arp = (ARP_DIV > 0);
`endif

    // Next state and next note: a fresh rise always wins, otherwise fall back off a released active key.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_strobe_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_key_rise) begin
                    w_state_nxt = PLAY;
                    w_idx_nxt   = lowest_set(w_rise16);
                end
            end
            PLAY: begin
                if (|w_key_rise) begin
                    w_idx_nxt = lowest_set(w_rise16);
                end else if (w_held == '0) begin
                    w_state_nxt = IDLE;
                end else if (!w_held16[r_idx]) begin
                    w_idx_nxt = lowest_set(w_held16);
                end
`ifdef TMNT_ARP_EN
                if (w_arp_ok) begin
                    w_state_nxt = ARP;
                end
`endif
            end
`ifdef TMNT_ARP_EN
            ARP: begin
                if (w_held == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    if (|w_key_rise) begin
                        w_idx_nxt = lowest_set(w_rise16);
                    end else if (!w_held16[r_idx]) begin
                        w_idx_nxt = lowest_set(w_held16);
                    end else if (w_arp_ok && w_arp_tick) begin
                        w_idx_nxt = next_set(w_held16, r_idx);
                    end
                    if (!w_arp_ok) begin
                        w_state_nxt = PLAY;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Strobe whenever the generator must reload: note appears, or a playing note changes.
        w_strobe_nxt = (w_state_nxt != IDLE) && ((r_state == IDLE) || (w_idx_nxt != r_idx));
    end

    // State, note and strobe all register together so outputs change on one edge.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign note_valid  = (r_state != IDLE);
    assign note_idx    = r_idx;
    assign note_strobe = r_strobe;
    assign mode        = r_mode;

endmodule

// File: tb/tb_tmnt_note_arbiter.sv
// Bench for tmnt_note_arbiter: stable key patterns held long enough to settle, then note/strobe/mode compared.
// Latency: each step holds inputs 40 clk (worst settle is 12 clk with DEB_DIV=4).
// Backpressure: n/a.
module tb_tmnt_note_arbiter;

    localparam int N_KEYS  = 13;
    localparam int DEB_DIV = 4;
    localparam int ARP_DIV = 8;
    localparam int HOLD    = 40;
    localparam int NVEC    = 16;

    logic              clk         = 1'b0;
    logic              gated_reset = 1'b1;
    logic [N_KEYS-1:0] keys        = '0;
    logic              mode_btn    = 1'b0;
    logic              note_valid;
    logic [3:0]        note_idx;
    logic              note_strobe;
    logic [1:0]        mode;

    int n_checks   = 0;
    int n_pass     = 0;
    int strobe_cnt = 0;

    typedef struct {
        logic [N_KEYS-1:0] keys;
        logic              exp_valid;
        int                exp_idx;
        int                exp_strobes;
    } vec_t;

    vec_t vecs [NVEC];

    tmnt_note_arbiter #(
        .N_KEYS  (N_KEYS),
        .DEB_DIV (DEB_DIV),
        .ARP_DIV (ARP_DIV)
    ) dut (
        .clk         (clk),
        .gated_reset (gated_reset),
        .keys        (keys),
        .mode_btn    (mode_btn),
        .note_valid  (note_valid),
        .note_idx    (note_idx),
        .note_strobe (note_strobe),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_step(input string name, input logic [N_KEYS-1:0] kv,
                              input int ev, input int ei, input int es);
        int s0;
        keys = kv;
        s0   = strobe_cnt;
        tick(HOLD);
        check({name, "_valid"}, int'(note_valid), ev);
        check({name, "_idx"}, int'(note_idx), ei);
        check({name, "_strobes"}, strobe_cnt - s0, es);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 gated_reset = 1'b0;
        tick(3);
        gated_reset = 1'b1;
        tick(2);
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        tick(20);
        mode_btn = 1'b0;
        tick(20);
    endtask

    function automatic int lowest(input logic [N_KEYS-1:0] v);
        for (int i = 0; i < N_KEYS; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial begin
        int s0;
        int found;
        int mode_exp [5];
        logic [N_KEYS-1:0] kv;
        logic [N_KEYS-1:0] hp;
        logic [N_KEYS-1:0] rv;
        int a;
        int na;
        int v;
        int nv;
        int es;

        // Pattern, expected valid, expected idx, expected strobe count during the step.
        vecs[0]  = '{13'h0000, 1'b0, 0,  0};
        vecs[1]  = '{13'h0020, 1'b1, 5,  1};
        vecs[2]  = '{13'h0000, 1'b0, 5,  0};
        vecs[3]  = '{13'h0080, 1'b1, 7,  1};
        vecs[4]  = '{13'h0084, 1'b1, 2,  1};
        vecs[5]  = '{13'h0080, 1'b1, 7,  1};
        vecs[6]  = '{13'h1080, 1'b1, 12, 1};
        vecs[7]  = '{13'h1000, 1'b1, 12, 0};
        vecs[8]  = '{13'h0000, 1'b0, 12, 0};
        vecs[9]  = '{13'h0210, 1'b1, 4,  1};
        vecs[10] = '{13'h0A00, 1'b1, 11, 1};
        vecs[11] = '{13'h0A42, 1'b1, 1,  1};
        vecs[12] = '{13'h0200, 1'b1, 9,  1};
        vecs[13] = '{13'h0000, 1'b0, 9,  0};
        vecs[14] = '{13'h0200, 1'b1, 9,  1};
        vecs[15] = '{13'h0000, 1'b0, 9,  0};
        mode_exp = '{1, 2, 3, 0, 1};

        // Reset state.
        #2 gated_reset = 1'b0;
        tick(3);
        check("rst_valid", int'(note_valid), 0);
        check("rst_idx", int'(note_idx), 0);
        check("rst_strobe", int'(note_strobe), 0);
        check("rst_mode", int'(mode), 0);
        gated_reset = 1'b1;
        tick(2);

        // Table-driven arbitration sequence.
        for (int i = 0; i < NVEC; i++) begin
            apply_step($sformatf("vec%0d", i), vecs[i].keys, int'(vecs[i].exp_valid),
                       vecs[i].exp_idx, vecs[i].exp_strobes);
        end

        // Press and release latency bounds, single strobe on press.
        keys  = 13'h0020;
        s0    = strobe_cnt;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (note_valid) found = 1;
        end
        check("press_within_12", found, 1);
        tick(20);
        check("press_idx", int'(note_idx), 5);
        check("press_strobes", strobe_cnt - s0, 1);
        keys  = '0;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (!note_valid) found = 1;
        end
        check("release_within_12", found, 1);
        tick(20);

        // One-cycle glitch on key 0 while 9 and 4 are held.
        apply_step("glitch_pre", 13'h0210, 1, 4, 1);
        s0      = strobe_cnt;
        keys[0] = 1'b1;
        tick(1);
        keys[0] = 1'b0;
        tick(HOLD);
        check("glitch_idx", int'(note_idx), 4);
        check("glitch_strobes", strobe_cnt - s0, 0);
        apply_step("glitch_post", 13'h0000, 0, 4, 0);

        // Mode button cycling.
        for (int k = 0; k < 5; k++) begin
            press_mode();
            check($sformatf("mode_press%0d", k), int'(mode), mode_exp[k]);
        end

        // Reset mid-PLAY with key still held.
        apply_step("rstplay_pre", 13'h0008, 1, 3, 1);
        @(posedge clk);
        #1 gated_reset = 1'b0;
        #1;
        check("rstplay_valid", int'(note_valid), 0);
        check("rstplay_idx", int'(note_idx), 0);
        check("rstplay_strobe", int'(note_strobe), 0);
        check("rstplay_mode", int'(mode), 0);
        tick(3);
        gated_reset = 1'b1;
        s0 = strobe_cnt;
        tick(HOLD);
        check("rstplay_reacq_valid", int'(note_valid), 1);
        check("rstplay_reacq_idx", int'(note_idx), 3);
        check("rstplay_reacq_strobes", strobe_cnt - s0, 1);
        apply_step("rstplay_post", 13'h0000, 0, 3, 0);

`ifdef TMNT_ARP_EN
        // Arpeggio over keys 1, 3, 6 in mode 11.
        begin
            int arp_exp [3];
            int last_cyc;
            int cyc;
            arp_exp = '{3, 6, 1};
            do_reset();
            press_mode();
            press_mode();
            press_mode();
            check("arp_mode", int'(mode), 3);
            keys  = 13'h004A;
            found = 0;
            for (int i = 0; i < 14 && found == 0; i++) begin
                @(posedge clk);
                #1;
                if (note_valid) found = 1;
            end
            check("arp_start_valid", found, 1);
            check("arp_start_idx", int'(note_idx), 1);
            last_cyc = 0;
            cyc      = 0;
            for (int s = 0; s < 3; s++) begin
                found = 0;
                for (int i = 0; i < 12 && found == 0; i++) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (note_strobe) found = 1;
                end
                check($sformatf("arp_step%0d_seen", s), found, 1);
                check($sformatf("arp_step%0d_idx", s), int'(note_idx), arp_exp[s]);
                if (s > 0) check($sformatf("arp_step%0d_period", s), cyc - last_cyc, ARP_DIV);
                last_cyc = cyc;
            end
            keys = '0;
            tick(HOLD);
        end
`endif

        // Randomised patterns against a set-level model of the arbitration rules.
        do_reset();
`ifndef TMNT_ARP_EN
        press_mode();
        press_mode();
        press_mode();
        check("rand_mode11", int'(mode), 3);
`endif
        hp = '0;
        a  = 0;
        v  = 0;
        for (int it = 0; it < 60; it++) begin
            kv = N_KEYS'($urandom) & N_KEYS'($urandom);
            if ((it % 5) == 4) kv = '0;
            rv = kv & ~hp;
            na = a;
            nv = v;
            if (rv != '0) begin
                na = lowest(rv);
                nv = 1;
            end else if (kv == '0) begin
                nv = 0;
            end else if (v != 0 && !kv[a]) begin
                na = lowest(kv);
            end
            es = (nv != 0 && (v == 0 || na != a)) ? 1 : 0;
            apply_step($sformatf("rand%0d", it), kv, nv, na, es);
            hp = kv;
            a  = na;
            v  = nv;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
